// File: rtl/brq_pkg.sv
// ---------------------------------------------------------------------------
// brq_pkg -- shared definitions for the branch resolve queue.
//
// Contents:
//   BRQ_PC_W      default branch PC width (matches predictor pc_D/pc_E)
//   BRQ_DEPTH     default queue depth (power of two, 2..16)
//   BRQ_PC_MAX_W  widest PC an entry can hold; narrower PCs are zero-extended
//   brq_entry_t   one queued branch: {pc, pred}
// ---------------------------------------------------------------------------
package brq_pkg;

    localparam int BRQ_PC_W     = 10;
    localparam int BRQ_DEPTH    = 4;
    localparam int BRQ_PC_MAX_W = 32;

    // The entry is sized for the widest supported PC so that one struct type
    // serves every PC_W instance; unused upper bits are always written as 0.
    typedef struct packed {
        logic [BRQ_PC_MAX_W-1:0] pc;
        logic                    pred;
    } brq_entry_t;

endpackage

// File: rtl/brq_fifo.sv
// ---------------------------------------------------------------------------
// brq_fifo -- circular storage for in-flight predicted branches.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (pointers/count only)
//   push_en      write push_data at the tail (caller has already qualified it)
//   push_data    entry to enqueue
//   pop_en       advance the head (caller guarantees the queue is not empty)
//   flush        discard every entry; overrides push_en/pop_en
//   head_data    entry at the head (meaningless while empty)
//   count        current occupancy
//   full/empty   occupancy flags, decoded from the registered count
// ---------------------------------------------------------------------------
module brq_fifo
    import brq_pkg::*;
#(
    parameter int DEPTH = BRQ_DEPTH,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_en,
    input  brq_entry_t    push_data,
    input  logic          pop_en,
    input  logic          flush,
    output brq_entry_t    head_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    brq_entry_t    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // DEPTH is a power of two, so plain pointer overflow wraps modulo DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push_en) - CW'(pop_en);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push_en && !flush) mem_q[wr_ptr_q] <= push_data;
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);

endmodule

// File: rtl/branch_resolve_queue.sv
// ---------------------------------------------------------------------------
// branch_resolve_queue -- tracks predicted branches from decode until execute
// resolves them, feeds the outcome back to the predictor and raises a flush
// on a misprediction.
//
// Optional feature macro: BRQ_STATS_EN (adds stat_resolved / stat_mispred).
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   push, push_pc, push_pred      decode enqueues a predicted branch
//   resolve_valid, resolve_pc,    execute resolves the oldest branch
//   resolve_taken
//   full, empty, count            occupancy
//   update_enable/value/pc        registered one-cycle predictor update
//   mispredict                    registered one-cycle flush pulse
//   order_error                   sticky: resolve_pc differed from head PC
//   stat_resolved, stat_mispred   (BRQ_STATS_EN) saturating 16-bit counters
// ---------------------------------------------------------------------------
module branch_resolve_queue
    import brq_pkg::*;
#(
    parameter int PC_W  = BRQ_PC_W,
    parameter int DEPTH = BRQ_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [PC_W-1:0]            push_pc,
    input  logic                       push_pred,
    input  logic                       resolve_valid,
    input  logic [PC_W-1:0]            resolve_pc,
    input  logic                       resolve_taken,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       update_enable,
    output logic                       update_value,
    output logic [PC_W-1:0]            update_pc,
    output logic                       mispredict,
    output logic                       order_error
`ifdef BRQ_STATS_EN
    ,
    output logic [15:0]                stat_resolved,
    output logic [15:0]                stat_mispred
`endif
);

    brq_entry_t push_entry;
    brq_entry_t head_entry;
    logic       pop_accept;
    logic       mis_now;
    logic       pc_mismatch;
    logic       push_accept;

    logic            update_enable_q;
    logic            update_value_q;
    logic [PC_W-1:0] update_pc_q;
    logic            mispredict_q;
    logic            order_error_q, order_error_d;

    always_comb begin
        push_entry      = '0;
        push_entry.pc   = BRQ_PC_MAX_W'(push_pc);
        push_entry.pred = push_pred;
    end

    assign pop_accept  = resolve_valid && !empty;
    assign mis_now     = pop_accept && (resolve_taken != head_entry.pred);
    assign pc_mismatch = pop_accept && (head_entry.pc != BRQ_PC_MAX_W'(resolve_pc));
    // A same-cycle pop frees a slot when full, but a mispredicting pop flushes
    // the queue and the decode-stage branch is on the wrong path, so drop it.
    assign push_accept = push && !mis_now && (!full || pop_accept);

    brq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_en   (push_accept),
        .push_data (push_entry),
        .pop_en    (pop_accept),
        .flush     (mis_now),
        .head_data (head_entry),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    assign order_error_d = order_error_q || pc_mismatch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            update_enable_q <= 1'b0;
            update_value_q  <= 1'b0;
            update_pc_q     <= '0;
            mispredict_q    <= 1'b0;
            order_error_q   <= 1'b0;
        end else begin
            update_enable_q <= pop_accept;
            mispredict_q    <= mis_now;
            order_error_q   <= order_error_d;
            // The predictor is trained with the PC execute reports, even when
            // it disagrees with the queued PC.
            if (pop_accept) begin
                update_value_q <= resolve_taken;
                update_pc_q    <= resolve_pc;
            end
        end
    end

    assign update_enable = update_enable_q;
    assign update_value  = update_value_q;
    assign update_pc     = update_pc_q;
    assign mispredict    = mispredict_q;
    assign order_error   = order_error_q;

`ifdef BRQ_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic inc);
        if (inc && (v != 16'hFFFF)) return v + 16'd1;
        return v;
    endfunction

    logic [15:0] stat_res_q, stat_res_d;
    logic [15:0] stat_mis_q, stat_mis_d;

    assign stat_res_d = sat_inc(stat_res_q, pop_accept);
    assign stat_mis_d = sat_inc(stat_mis_q, mis_now);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_res_q <= '0;
            stat_mis_q <= '0;
        end else begin
            stat_res_q <= stat_res_d;
            stat_mis_q <= stat_mis_d;
        end
    end

    assign stat_resolved = stat_res_q;
    assign stat_mispred  = stat_mis_q;
`endif

endmodule
